// File: rtl/pkt_seq_ctrl.sv
// -----------------------------------------------------------------------------
// pkt_seq_ctrl
//
// RX/TX sequencing controller for the RF packet datapath. Drives the load,
// enable and reset strobes of the shift buffer, packet register, SPI slave and
// TX buffer.
//
// RX side: on a new packet (rising pkt_rec) the packet register and SPI data
// register are loaded, then PKT_BYTES bytes are unloaded, one per SPI
// chip-select frame. The unload is abandoned if CS stays high for CS_TIMEOUT
// cycles.
// TX side: inside a CS frame, each received SPI byte is loaded into the TX
// buffer and shifted out under the bit-sync strobes. Up to the effective
// tx_len bytes are sent per frame.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   cfg_mode          1 = configuration mode, FSMs frozen
//   rx_mode           1 = RX, 0 = TX
//   pkt_rec           shift-buffer packet-complete level
//   cs_sync           synchronised SPI chip select, active low
//   spi_rx_valid      one-cycle SPI byte received pulse
//   sh_en             one-cycle bit strobe from bit sync
//   sh_en_done        bit sync end of burst
//   tx_len[3:0]       bytes per TX frame (0 -> 1, clamped to TX_MAX)
//   err_clr           clear sticky error flags
//   pkt_ld, spi_ld    packet register / SPI data load pulses
//   pkt_en            packet register byte-advance pulse
//   pkt_rst           shift buffer clear pulse
//   tx_ld, tx_en      TX buffer load / shift pulses
//   tx_sh             TX shift window to bit sync
//   rx_busy, tx_busy  FSM outside its idle/wait state
//   bytes_left[3:0]   remaining RX bytes to unload
//   err[1:0]          sticky flags: bit0 RX overrun, bit1 TX drop
//   timeout           one-cycle pulse on CS timeout
// All outputs are registered.
// -----------------------------------------------------------------------------
module pkt_seq_ctrl #(
    parameter int PKT_BYTES  = 3,
    parameter int TX_MAX     = 4,
    parameter int CS_TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_mode,
    input  logic       rx_mode,
    input  logic       pkt_rec,
    input  logic       cs_sync,
    input  logic       spi_rx_valid,
    input  logic       sh_en,
    input  logic       sh_en_done,
    input  logic [3:0] tx_len,
    input  logic       err_clr,
    output logic       pkt_ld,
    output logic       spi_ld,
    output logic       pkt_en,
    output logic       pkt_rst,
    output logic       tx_ld,
    output logic       tx_en,
    output logic       tx_sh,
    output logic       rx_busy,
    output logic       tx_busy,
    output logic [3:0] bytes_left,
    output logic [1:0] err,
    output logic       timeout
);

    typedef enum logic [2:0] {
        R_IDLE  = 3'd0,
        R_WAIT  = 3'd1,
        R_STORE = 3'd2,
        R_CS    = 3'd3,
        R_XFER  = 3'd4
    } rx_state_t;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_ARM  = 2'd1,
        T_SEND = 2'd2
    } tx_state_t;

    localparam logic [3:0]  PKT_N    = 4'(PKT_BYTES);
    localparam logic [3:0]  TX_CAP   = 4'(TX_MAX);
    localparam logic [15:0] TMO_LAST = 16'(CS_TIMEOUT - 1);

    rx_state_t   rx_state_q, rx_state_d;
    tx_state_t   tx_state_q, tx_state_d;
    logic [3:0]  bytes_left_q, bytes_left_d;
    logic [15:0] timer_q, timer_d;
    logic [3:0]  byte_cnt_q, byte_cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic        pkt_rec_prev_q, pkt_rec_prev_d;
    logic [1:0]  err_q, err_d;
    logic        pkt_ld_q, pkt_ld_d;
    logic        spi_ld_q, spi_ld_d;
    logic        pkt_en_q, pkt_en_d;
    logic        pkt_rst_q, pkt_rst_d;
    logic        tx_ld_q, tx_ld_d;
    logic        tx_en_q, tx_en_d;
    logic        tx_sh_q, tx_sh_d;
    logic        rx_busy_q, rx_busy_d;
    logic        tx_busy_q, tx_busy_d;
    logic        timeout_q, timeout_d;

    logic        rise;
    logic [3:0]  eff_len;
    logic [3:0]  byte_next;
    logic [1:0]  err_set;

    assign rise = pkt_rec & ~pkt_rec_prev_q;

    // Effective TX frame length: 0 means one byte, anything above TX_MAX is capped.
    always_comb begin
        eff_len = tx_len;
        if (tx_len == 4'd0) begin
            eff_len = 4'd1;
        end else if (tx_len > TX_CAP) begin
            eff_len = TX_CAP;
        end
    end

    always_comb begin
        rx_state_d     = rx_state_q;
        tx_state_d     = tx_state_q;
        bytes_left_d   = bytes_left_q;
        timer_d        = timer_q;
        byte_cnt_d     = byte_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        pkt_rec_prev_d = pkt_rec_prev_q;
        err_d          = err_q;
        pkt_ld_d       = 1'b0;
        spi_ld_d       = 1'b0;
        pkt_en_d       = 1'b0;
        pkt_rst_d      = 1'b0;
        tx_ld_d        = 1'b0;
        tx_en_d        = 1'b0;
        tx_sh_d        = 1'b0;
        timeout_d      = 1'b0;
        err_set        = 2'b00;
        byte_next      = byte_cnt_q + 4'd1;

        // In configuration mode everything holds and only the pulses drop.
        if (!cfg_mode) begin
            pkt_rec_prev_d = pkt_rec;

            // ---------------- RX FSM ----------------
            if (!rx_mode) begin
                rx_state_d = R_IDLE;
                timer_d    = '0;
            end else begin
                case (rx_state_q)
                    R_IDLE: begin
                        timer_d    = '0;
                        rx_state_d = R_WAIT;
                    end
                    R_WAIT: begin
                        bytes_left_d = PKT_N;
                        if (rise) begin
                            pkt_ld_d   = 1'b1;
                            spi_ld_d   = 1'b1;
                            rx_state_d = R_STORE;
                        end
                    end
                    R_STORE: begin
                        pkt_rst_d  = 1'b1;
                        timer_d    = '0;
                        rx_state_d = R_CS;
                    end
                    R_CS: begin
                        if (bytes_left_q == 4'd0) begin
                            rx_state_d = R_WAIT;
                        end else if (!cs_sync) begin
                            rx_state_d = R_XFER;
                        end else if (timer_q == TMO_LAST) begin
                            // Host never came for the data: drop the rest of the packet.
                            timeout_d    = 1'b1;
                            bytes_left_d = '0;
                            rx_state_d   = R_WAIT;
                        end else begin
                            timer_d = timer_q + 16'd1;
                        end
                    end
                    R_XFER: begin
                        if (cs_sync) begin
                            pkt_en_d = 1'b1;
                            if (bytes_left_q != 4'd0) begin
                                bytes_left_d = bytes_left_q - 4'd1;
                            end
                            rx_state_d = R_STORE;
                        end
                    end
                    default: rx_state_d = R_IDLE;
                endcase

                // A new packet while an unload is in progress is flagged and dropped.
                if (rise && (rx_state_q != R_WAIT)) begin
                    err_set[0] = 1'b1;
                end
            end

            // ---------------- TX FSM ----------------
            if (rx_mode) begin
                tx_state_d = T_IDLE;
                byte_cnt_d = '0;
                bit_cnt_d  = '0;
            end else begin
                case (tx_state_q)
                    T_IDLE: begin
                        byte_cnt_d = '0;
                        bit_cnt_d  = '0;
                        if (!cs_sync) begin
                            tx_state_d = T_ARM;
                        end
                    end
                    T_ARM: begin
                        if (spi_rx_valid) begin
                            tx_ld_d    = 1'b1;
                            bit_cnt_d  = '0;
                            tx_state_d = T_SEND;
                        end
                    end
                    T_SEND: begin
                        if (spi_rx_valid) begin
                            err_set[1] = 1'b1;
                        end
                        // bit_cnt reaching 8 is acted on one cycle after the 8th
                        // tx_en, so tx_sh covers the last shift. sh_en_done wins
                        // over a coincident sh_en.
                        if ((bit_cnt_q == 4'd8) || sh_en_done) begin
                            byte_cnt_d = byte_next;
                            if ((byte_next >= eff_len) || cs_sync) begin
                                tx_state_d = T_IDLE;
                            end else begin
                                tx_state_d = T_ARM;
                            end
                        end else begin
                            tx_sh_d = 1'b1;
                            if (sh_en) begin
                                tx_en_d   = 1'b1;
                                bit_cnt_d = bit_cnt_q + 4'd1;
                            end
                        end
                    end
                    default: tx_state_d = T_IDLE;
                endcase
            end

            // Set wins over a same-cycle clear.
            err_d = err_set | (err_clr ? 2'b00 : err_q);
        end

        rx_busy_d = (rx_state_d == R_STORE) || (rx_state_d == R_CS) || (rx_state_d == R_XFER);
        tx_busy_d = (tx_state_d != T_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_q     <= R_IDLE;
            tx_state_q     <= T_IDLE;
            bytes_left_q   <= '0;
            timer_q        <= '0;
            byte_cnt_q     <= '0;
            bit_cnt_q      <= '0;
            pkt_rec_prev_q <= 1'b0;
            err_q          <= '0;
            pkt_ld_q       <= 1'b0;
            spi_ld_q       <= 1'b0;
            pkt_en_q       <= 1'b0;
            pkt_rst_q      <= 1'b0;
            tx_ld_q        <= 1'b0;
            tx_en_q        <= 1'b0;
            tx_sh_q        <= 1'b0;
            rx_busy_q      <= 1'b0;
            tx_busy_q      <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            rx_state_q     <= rx_state_d;
            tx_state_q     <= tx_state_d;
            bytes_left_q   <= bytes_left_d;
            timer_q        <= timer_d;
            byte_cnt_q     <= byte_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            pkt_rec_prev_q <= pkt_rec_prev_d;
            err_q          <= err_d;
            pkt_ld_q       <= pkt_ld_d;
            spi_ld_q       <= spi_ld_d;
            pkt_en_q       <= pkt_en_d;
            pkt_rst_q      <= pkt_rst_d;
            tx_ld_q        <= tx_ld_d;
            tx_en_q        <= tx_en_d;
            tx_sh_q        <= tx_sh_d;
            rx_busy_q      <= rx_busy_d;
            tx_busy_q      <= tx_busy_d;
            timeout_q      <= timeout_d;
        end
    end

    assign pkt_ld     = pkt_ld_q;
    assign spi_ld     = spi_ld_q;
    assign pkt_en     = pkt_en_q;
    assign pkt_rst    = pkt_rst_q;
    assign tx_ld      = tx_ld_q;
    assign tx_en      = tx_en_q;
    assign tx_sh      = tx_sh_q;
    assign rx_busy    = rx_busy_q;
    assign tx_busy    = tx_busy_q;
    assign bytes_left = bytes_left_q;
    assign err        = err_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_pkt_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pkt_seq_ctrl
//
// Scoreboard bench for pkt_seq_ctrl (PKT_BYTES=3, TX_MAX=4, CS_TIMEOUT=100).
// Every cycle in which any strobe is high is an "event" word
// {tx_sh, err, bytes_left, strobes}; the stimulus pushes the events it expects
// and a negedge monitor pops and compares them. Level behaviour (busy, err,
// latency, reset) is compared directly.
// -----------------------------------------------------------------------------
module tb_pkt_seq_ctrl;

    localparam int P_TXEN   = 1;
    localparam int P_TXLD   = 2;
    localparam int P_PKTLD  = 4;
    localparam int P_SPILD  = 8;
    localparam int P_PKTEN  = 16;
    localparam int P_PKTRST = 32;
    localparam int P_TMO    = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_mode = 1'b0;
    logic       rx_mode = 1'b1;
    logic       pkt_rec = 1'b0;
    logic       cs_sync = 1'b1;
    logic       spi_rx_valid = 1'b0;
    logic       sh_en = 1'b0;
    logic       sh_en_done = 1'b0;
    logic [3:0] tx_len = 4'd0;
    logic       err_clr = 1'b0;
    logic       pkt_ld, spi_ld, pkt_en, pkt_rst, tx_ld, tx_en, tx_sh;
    logic       rx_busy, tx_busy, timeout;
    logic [3:0] bytes_left;
    logic [1:0] err;

    int vectors = 0;
    int miscompares = 0;

    logic [13:0] sb_q[$];
    logic [13:0] obs_w;
    logic [13:0] exp_w;
    logic [15:0] all_out;

    pkt_seq_ctrl #(
        .PKT_BYTES (3),
        .TX_MAX    (4),
        .CS_TIMEOUT(100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_mode    (cfg_mode),
        .rx_mode     (rx_mode),
        .pkt_rec     (pkt_rec),
        .cs_sync     (cs_sync),
        .spi_rx_valid(spi_rx_valid),
        .sh_en       (sh_en),
        .sh_en_done  (sh_en_done),
        .tx_len      (tx_len),
        .err_clr     (err_clr),
        .pkt_ld      (pkt_ld),
        .spi_ld      (spi_ld),
        .pkt_en      (pkt_en),
        .pkt_rst     (pkt_rst),
        .tx_ld       (tx_ld),
        .tx_en       (tx_en),
        .tx_sh       (tx_sh),
        .rx_busy     (rx_busy),
        .tx_busy     (tx_busy),
        .bytes_left  (bytes_left),
        .err         (err),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    assign obs_w   = {tx_sh, err, bytes_left, timeout, pkt_rst, pkt_en, spi_ld, pkt_ld, tx_ld, tx_en};
    assign all_out = {pkt_ld, spi_ld, pkt_en, pkt_rst, tx_ld, tx_en, tx_sh,
                      rx_busy, tx_busy, bytes_left, err, timeout};

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic logic [13:0] ev(input int p, input int bl, input int er, input int sh);
        return {1'(sh), 2'(er), 4'(bl), 7'(p)};
    endfunction

    // Event monitor: every strobe cycle must match the next expected event.
    always @(negedge clk) begin
        if (obs_w[6:0] != 7'd0) begin
            if (sb_q.size() == 0) begin
                chk_eq("unexpected_event", 32'(obs_w), 32'd0);
            end else begin
                exp_w = sb_q.pop_front();
                chk_eq("event", 32'(obs_w), 32'(exp_w));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One CS low/high frame unloading one byte; optionally a second packet
    // arrives while the byte is in transfer.
    task automatic rx_frame(input bit ovr, input int bl_after, input int er);
        cs_sync = 1'b0;
        if (ovr) begin
            tick(1);
            pkt_rec = 1'b0;
            tick(1);
            pkt_rec = 1'b1;
            tick(1);
        end else begin
            tick(3);
        end
        cs_sync = 1'b1;
        sb_q.push_back(ev(P_PKTEN, bl_after, er, 0));
        sb_q.push_back(ev(P_PKTRST, bl_after, er, 0));
        tick(3);
    endtask

    // New packet: rising pkt_rec, expect load then shift-buffer clear.
    task automatic rx_start(input int er);
        pkt_rec = 1'b0;
        tick(1);
        pkt_rec = 1'b1;
        sb_q.push_back(ev(P_PKTLD | P_SPILD, 3, er, 0));
        sb_q.push_back(ev(P_PKTRST, 3, er, 0));
    endtask

    // One TX byte: SPI byte arrives, nbits shift strobes, optional
    // sh_en_done (with a coincident sh_en), optional dropped SPI byte
    // (with a same-cycle err_clr) after strobe drop_at.
    task automatic tx_byte(input int nbits, input bit use_done, input int drop_at,
                           input bit busy_exp, input int er_in);
        int er;
        er = er_in;
        spi_rx_valid = 1'b1;
        sb_q.push_back(ev(P_TXLD, 3, er, 0));
        tick(1);
        spi_rx_valid = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            sh_en = 1'b1;
            sb_q.push_back(ev(P_TXEN, 3, er, 1));
            tick(1);
            sh_en = 1'b0;
            if (i == drop_at) begin
                spi_rx_valid = 1'b1;
                err_clr      = 1'b1;
                er           = 2;
            end
            tick(1);
            spi_rx_valid = 1'b0;
            err_clr      = 1'b0;
        end
        if (use_done) begin
            sh_en_done = 1'b1;
            sh_en      = 1'b1;
            tick(1);
            sh_en_done = 1'b0;
            sh_en      = 1'b0;
        end
        chk_eq("tx_sh_after_byte", 32'(tx_sh), 32'd0);
        chk_eq("tx_busy_after_byte", 32'(tx_busy), 32'(busy_exp));
        tick(2);
    endtask

    initial begin
        int k;

        // Reset state
        tick(2);
        chk_eq("reset_outputs", 32'(all_out), 32'd0);
        rst = 1'b1;
        tick(4);
        chk_eq("wait_rx_busy", 32'(rx_busy), 32'd0);
        chk_eq("wait_bytes_left", 32'(bytes_left), 32'd3);

        // Full 3-byte unload
        rx_start(0);
        tick(3);
        rx_frame(1'b0, 2, 0);
        rx_frame(1'b0, 1, 0);
        rx_frame(1'b0, 0, 0);
        tick(2);
        chk_eq("unload_done_busy", 32'(rx_busy), 32'd0);
        chk_eq("unload_done_bl", 32'(bytes_left), 32'd3);
        chk_eq("unload_done_err", 32'(err), 32'd0);

        // CS never asserted: timeout
        rx_start(0);
        sb_q.push_back(ev(P_TMO, 0, 0, 0));
        k = 0;
        while (k < 300) begin
            tick(1);
            k++;
            if (timeout) break;
        end
        chk_eq("timeout_latency", 32'(k), 32'd102);
        chk_eq("timeout_bl", 32'(bytes_left), 32'd0);

        // Following packet accepted, with an overrun during the first transfer
        rx_start(0);
        tick(3);
        rx_frame(1'b1, 2, 1);
        rx_frame(1'b0, 1, 1);
        rx_frame(1'b0, 0, 1);
        tick(2);
        chk_eq("overrun_err", 32'(err), 32'd1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk_eq("overrun_err_clr", 32'(err), 32'd0);

        // Configuration freeze mid-transfer with a CS toggle
        rx_start(0);
        tick(3);
        cs_sync = 1'b0;
        tick(2);
        cfg_mode = 1'b1;
        tick(3);
        cs_sync = 1'b1;
        tick(3);
        cs_sync = 1'b0;
        tick(4);
        chk_eq("cfg_rx_busy", 32'(rx_busy), 32'd1);
        chk_eq("cfg_bl_held", 32'(bytes_left), 32'd3);
        cfg_mode = 1'b0;
        tick(2);
        cs_sync = 1'b1;
        sb_q.push_back(ev(P_PKTEN, 2, 0, 0));
        sb_q.push_back(ev(P_PKTRST, 2, 0, 0));
        tick(3);
        rx_frame(1'b0, 1, 0);
        rx_frame(1'b0, 0, 0);
        tick(2);

        // TX mode
        rx_mode = 1'b0;
        tick(2);
        chk_eq("tx_idle_busy", 32'(tx_busy), 32'd0);
        chk_eq("tx_rx_busy", 32'(rx_busy), 32'd0);
        tx_len  = 4'd2;
        cs_sync = 1'b0;
        tick(2);
        chk_eq("tx_arm_busy", 32'(tx_busy), 32'd1);
        tx_byte(8, 1'b0, -1, 1'b1, 0);
        tx_byte(8, 1'b0, -1, 1'b0, 0);

        // tx_len=0 sends one byte
        tx_len = 4'd0;
        tx_byte(8, 1'b0, -1, 1'b0, 0);

        // tx_len above TX_MAX is clamped to 4 bytes
        tx_len = 4'd15;
        tx_byte(0, 1'b1, -1, 1'b1, 0);
        tx_byte(0, 1'b1, -1, 1'b1, 0);
        tx_byte(0, 1'b1, -1, 1'b1, 0);
        tx_byte(0, 1'b1, -1, 1'b0, 0);

        // Dropped SPI byte during send, then sh_en_done after 5 strobes
        tx_len = 4'd3;
        tx_byte(5, 1'b1, 1, 1'b1, 0);
        chk_eq("tx_drop_err", 32'(err), 32'd2);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk_eq("tx_drop_err_clr", 32'(err), 32'd0);

        // Asynchronous reset in the middle of a byte
        spi_rx_valid = 1'b1;
        sb_q.push_back(ev(P_TXLD, 3, 0, 0));
        tick(1);
        spi_rx_valid = 1'b0;
        sh_en = 1'b1;
        sb_q.push_back(ev(P_TXEN, 3, 0, 1));
        tick(1);
        sh_en = 1'b0;
        tick(1);
        chk_eq("pre_reset_tx_sh", 32'(tx_sh), 32'd1);
        chk_eq("pre_reset_tx_busy", 32'(tx_busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk_eq("async_reset_outputs", 32'(all_out), 32'd0);
        tick(2);
        rst = 1'b1;
        tick(2);

        chk_eq("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
